// File: rtl/sevenseg_scan_driver.sv
// sevenseg_scan_driver: multiplexed hex/decimal seven-segment driver with sequential double-dabble.
// Define SEVENSEG_LEADING_ZERO_BLANK_EN to blank zero digits above the highest nonzero digit.
module sevenseg_scan_driver #(
  parameter int DIGITS      = 4,
  parameter int VALUE_W     = 16,
  parameter int REFRESH_DIV = 1000
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic [VALUE_W-1:0] Value,
  input  logic               Load,
  input  logic               DecMode,
  output logic               Busy,
  output logic               Overflow,
  output logic [7:0]         SegOut,
  output logic [DIGITS-1:0]  DigitEn
);
  function automatic int dec_digits(int w);
    longint unsigned v;
    int n;
    v = (64'd1 << w) - 64'd1;
    n = 0;
    while (v != 0) begin
      v = v / 10;
      n++;
    end
    return n;
  endfunction
  localparam int BCD_N = dec_digits(VALUE_W);
  // one spare digit on top keeps the overflow slice non-empty for every parameter set
  localparam int ACC_N = (BCD_N > DIGITS ? BCD_N : DIGITS) + 1;
  localparam int HW    = (VALUE_W > 4*DIGITS ? VALUE_W : 4*DIGITS) + 1;
  localparam int CW    = $clog2(VALUE_W);
  localparam int RW    = $clog2(REFRESH_DIV + 1);
  localparam int IW    = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam logic [7:0] SEG_LUT [16] = '{
    8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
    8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};
  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;
  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [VALUE_W-1:0]      sh_q, sh_d;
  logic [4*ACC_N-1:0]      acc_q, acc_d, adj;
  logic [DIGITS-1:0][3:0]  disp_q, disp_d;
  logic                    ovf_q, ovf_d;
  logic [RW-1:0]           ref_q, ref_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [7:0]              seg_q, seg_d;
  logic [DIGITS-1:0]       en_q, en_d, blank;
  logic [HW-1:0]           vext;
  logic                    wrap;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    acc_d   = acc_q;
    disp_d  = disp_q;
    ovf_d   = ovf_q;
    vext    = HW'(Value);
    for (int i = 0; i < ACC_N; i++)
      adj[4*i +: 4] = acc_q[4*i +: 4] >= 4'd5 ? acc_q[4*i +: 4] + 4'd3 : acc_q[4*i +: 4];
    case (state_q)
      IDLE: begin
        if (Load && !DecMode) begin
          disp_d = vext[4*DIGITS-1:0];
          ovf_d  = |vext[HW-1:4*DIGITS];
        end else if (Load) begin
          state_d = SHIFT;
          cnt_d   = '0;
          sh_d    = Value;
          acc_d   = '0;
        end
      end
      SHIFT: begin
        acc_d   = {adj[4*ACC_N-2:0], sh_q[VALUE_W-1]};
        sh_d    = {sh_q[VALUE_W-2:0], 1'b0};
        cnt_d   = cnt_q + 1'b1;
        state_d = cnt_q == CW'(VALUE_W - 1) ? COMMIT : SHIFT;
      end
      COMMIT: begin
        disp_d  = acc_q[4*DIGITS-1:0];
        ovf_d   = |acc_q[4*ACC_N-1:4*DIGITS];
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    wrap  = ref_q == RW'(REFRESH_DIV - 1);
    ref_d = wrap ? '0 : ref_q + 1'b1;
    idx_d = !wrap ? idx_q : idx_q == IW'(DIGITS - 1) ? '0 : idx_q + 1'b1;
`ifdef SEVENSEG_LEADING_ZERO_BLANK_EN
    begin : lz
      logic seen;
      seen = 1'b0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
        seen     = seen | (disp_q[i] != 4'd0);
        blank[i] = !seen && (i != 0);
      end
    end
`else
    blank = '0;
`endif
    en_d  = DIGITS'(1) << idx_q;
    seg_d = blank[idx_q] ? 8'h00 : SEG_LUT[disp_q[idx_q]];
  end
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      acc_q   <= '0;
      disp_q  <= '0;
      ovf_q   <= 1'b0;
      ref_q   <= '0;
      idx_q   <= '0;
      seg_q   <= '0;
      en_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      acc_q   <= acc_d;
      disp_q  <= disp_d;
      ovf_q   <= ovf_d;
      ref_q   <= ref_d;
      idx_q   <= idx_d;
      seg_q   <= seg_d;
      en_q    <= en_d;
    end
  end
  assign Busy     = state_q != IDLE;
  assign Overflow = ovf_q;
  assign SegOut   = seg_q;
  assign DigitEn  = en_q;
endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// tb_sevenseg_scan_driver: checks two driver instances against a decimal/hex display model.
module tb_sevenseg_scan_driver;
  localparam logic [7:0] ENC [16] = '{
    8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
    8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};
`ifdef SEVENSEG_LEADING_ZERO_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif
  localparam logic [7:0] LZ = BLANK ? 8'h00 : 8'h3F;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic        rst;
  logic [15:0] a_value;
  logic        a_load, a_dec, a_busy, a_ovf;
  logic [7:0]  a_seg;
  logic [3:0]  a_en;
  logic [11:0] b_value;
  logic        b_load, b_dec, b_busy, b_ovf;
  logic [7:0]  b_seg;
  logic [1:0]  b_en;
  sevenseg_scan_driver #(.DIGITS(4), .VALUE_W(16), .REFRESH_DIV(4)) dut_a (
    .Clk(clk), .Rst(rst), .Value(a_value), .Load(a_load), .DecMode(a_dec),
    .Busy(a_busy), .Overflow(a_ovf), .SegOut(a_seg), .DigitEn(a_en));
  sevenseg_scan_driver #(.DIGITS(2), .VALUE_W(12), .REFRESH_DIV(1)) dut_b (
    .Clk(clk), .Rst(rst), .Value(b_value), .Load(b_load), .DecMode(b_dec),
    .Busy(b_busy), .Overflow(b_ovf), .SegOut(b_seg), .DigitEn(b_en));
  int checks = 0;
  int errors = 0;
  int m_val;
  bit m_dec;
  typedef struct {
    logic [11:0] v;
    bit          d;
    logic [7:0]  s0;
    logic [7:0]  s1;
    bit          ovf;
  } vec_t;
  vec_t tbl [9];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask
  function automatic logic [7:0] exp_a(int i);
    int base = m_dec ? 10 : 16;
    int shown = m_dec ? m_val % 10000 : m_val % 65536;
    int p = 1;
    for (int k = 0; k < i; k++) p *= base;
    if (BLANK && i > 0 && shown / p == 0) return 8'h00;
    return ENC[(shown / p) % base];
  endfunction
  task automatic load_a(input int v, input bit d, output int bc);
    @(negedge clk);
    a_value = 16'(v);
    a_dec   = d;
    a_load  = 1'b1;
    @(negedge clk);
    a_load = 1'b0;
    bc = 0;
    while (a_busy && bc < 100) begin
      bc++;
      @(negedge clk);
    end
  endtask
  task automatic read_a(input string tag);
    @(negedge clk);
    chk({tag, " ovf"}, a_ovf, m_dec && m_val >= 10000);
    repeat (16) begin
      @(negedge clk);
      chk({tag, " onehot"}, $onehot(a_en), 1);
      for (int k = 0; k < 4; k++) if (a_en[k]) chk({tag, " seg"}, a_seg, exp_a(k));
    end
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    int bc;
    int v;
    bit d;
    rst = 1'b1;
    a_value = '0; a_load = 1'b0; a_dec = 1'b0;
    b_value = '0; b_load = 1'b0; b_dec = 1'b0;
    m_val = 0; m_dec = 1'b0;
    @(negedge clk);
    chk("reset busy", a_busy, 0);
    chk("reset ovf", a_ovf, 0);
    chk("reset seg", a_seg, 0);
    chk("reset en", a_en, 0);
    chk("reset b en", b_en, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      if (k == 6) begin a_value = 16'd1234; a_dec = 1'b1; a_load = 1'b1; end
      if (k == 7) a_load = 1'b0;
      @(negedge clk);
      chk("scan en", a_en, 1 << (((k - 1) / 4) % 4));
    end
    m_val = 1234; m_dec = 1'b1;
    read_a("scan load");
    load_a(1234, 1'b1, bc);
    chk("busy 1234", bc, 17);
    read_a("dec 1234");
    load_a(12345, 1'b1, bc);
    chk("busy 12345", bc, 17);
    m_val = 12345;
    read_a("dec 12345");
    load_a(16'h00FF, 1'b0, bc);
    chk("busy hex", bc, 0);
    m_val = 16'h00FF; m_dec = 1'b0;
    read_a("hex 00ff");
    repeat (25) begin
      case ($urandom_range(0, 5))
        0: v = 0;
        1: v = 9999;
        2: v = 10000;
        3: v = 65535;
        default: v = int'($urandom_range(0, 65535));
      endcase
      d = 1'($urandom_range(0, 1));
      load_a(v, d, bc);
      chk("rand busy", bc, d ? 17 : 0);
      m_val = v; m_dec = d;
      read_a("rand");
    end
    @(negedge clk);
    a_value = 16'd9999; a_dec = 1'b1; a_load = 1'b1;
    @(negedge clk);
    a_load = 1'b0;
    repeat (3) begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) if (a_en[k]) chk("old display", a_seg, exp_a(k));
    end
    a_value = 16'd1; a_load = 1'b1;
    @(negedge clk);
    a_load = 1'b0;
    bc = 0;
    while (a_busy && bc < 100) begin
      bc++;
      @(negedge clk);
    end
    chk("ignored busy", bc, 13);
    m_val = 9999; m_dec = 1'b1;
    read_a("ignored load");
    load_a(12345, 1'b1, bc);
    @(negedge clk);
    a_value = 16'd4321; a_dec = 1'b1; a_load = 1'b1;
    @(negedge clk);
    a_load = 1'b0;
    repeat (3) @(negedge clk);
    a_value = 16'd1; a_load = 1'b1;
    @(negedge clk);
    a_load = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst busy", a_busy, 0);
    chk("midrst seg", a_seg, 0);
    chk("midrst en", a_en, 0);
    chk("midrst ovf", a_ovf, 0);
    @(negedge clk);
    rst = 1'b0;
    m_val = 0; m_dec = 1'b0;
    read_a("after reset");
    tbl[0] = '{12'h045, 1'b0, 8'h6D, 8'h66, 1'b0};
    tbl[1] = '{12'h345, 1'b0, 8'h6D, 8'h66, 1'b1};
    tbl[2] = '{12'h0F0, 1'b0, 8'h3F, 8'h71, 1'b0};
    tbl[3] = '{12'h007, 1'b0, 8'h07, LZ,    1'b0};
    tbl[4] = '{12'd99,  1'b1, 8'h6F, 8'h6F, 1'b0};
    tbl[5] = '{12'd100, 1'b1, 8'h3F, LZ,    1'b1};
    tbl[6] = '{12'd4095,1'b1, 8'h6D, 8'h6F, 1'b1};
    tbl[7] = '{12'd0,   1'b1, 8'h3F, LZ,    1'b0};
    tbl[8] = '{12'd42,  1'b1, 8'h5B, 8'h66, 1'b0};
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      b_value = tbl[i].v; b_dec = tbl[i].d; b_load = 1'b1;
      @(negedge clk);
      b_load = 1'b0;
      bc = 0;
      while (b_busy && bc < 100) begin
        bc++;
        @(negedge clk);
      end
      chk("b busy", bc, tbl[i].d ? 13 : 0);
      @(negedge clk);
      chk("b ovf", b_ovf, tbl[i].ovf);
      repeat (4) begin
        @(negedge clk);
        chk("b onehot", $onehot(b_en), 1);
        chk("b seg", b_seg, b_en[0] ? tbl[i].s0 : tbl[i].s1);
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sevenseg_scan_driver.md
Name: sevenseg_scan_driver

Overview:
- Parametrised multiplexed seven-segment driver, DIGITS wide.
- Captures a binary Value on a Load pulse and shows it in hex (direct nibbles) or decimal (sequential double-dabble conversion).
- Time-multiplexes the digits onto one shared segment bus with a one-hot digit enable.
- Sits between core datapath registers and the board display pins.

Parameters:
- DIGITS, 4, number of display digits (1..8).
- VALUE_W, 16, width of the Value input (4..32).
- REFRESH_DIV, 1000, clock cycles each digit stays enabled (>=1).

Ports:
- Clk  in  1  system clock, rising edge.
- Rst  in  1  asynchronous, active-high reset.
- Value  in  VALUE_W  unsigned binary value to display.
- Load  in  1  single-cycle capture strobe.
- DecMode  in  1  1 = decimal, 0 = hex; sampled with Load.
- Busy  out  1  decimal conversion in progress.
- Overflow  out  1  captured value did not fit in DIGITS digits.
- SegOut  out  8  active-high segments {dp,g,f,e,d,c,b,a} for the enabled digit.
- DigitEn  out  DIGITS  one-hot active-high digit select; bit 0 = least significant digit.

Behaviour:
- Encoding, dp always 0: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
- Reset (async, any time, including mid-conversion):
  - Busy=0, Overflow=0, SegOut=0, DigitEn=0.
  - Display register cleared to all-zero digits; conversion aborted; refresh counter=0; digit index=0.
- FSM states: IDLE, SHIFT, COMMIT.
- IDLE:
  - Load=1 with DecMode=0 (hex): display register <= low 4*DIGITS bits of Value at that edge; Overflow <= (any Value bit above 4*DIGITS set). Stay IDLE; Busy stays 0.
  - Load=1 with DecMode=1: capture Value into the shift register, clear the BCD accumulator, set Busy=1, go to SHIFT.
- SHIFT:
  - Exactly VALUE_W cycles, one double-dabble step each: add 3 to every BCD nibble >=5, then shift left one bit, pulling in the binary MSB.
  - The BCD accumulator holds the full decimal range of VALUE_W (5 digits for 16 bits).
- COMMIT (1 cycle):
  - Display register <= low DIGITS BCD digits.
  - Overflow <= any higher BCD digit nonzero.
  - Busy <= 0; return to IDLE.
- Decimal latency: Busy high for VALUE_W+1 cycles after the Load edge; the new digits are visible from the edge that clears Busy.
- Load while Busy=1 is ignored, with no queuing. The display keeps its old contents until COMMIT.
- Scan logic:
  - Refresh counter runs 0..REFRESH_DIV-1 continuously, independent of the FSM.
  - On wrap, digit index advances; DIGITS-1 wraps to 0.
- Outputs:
  - SegOut and DigitEn are registered from the digit index and display register, one cycle behind the index.
  - After reset release, first valid output is DigitEn=1 at the first clock.
  - SegOut and DigitEn change on the same edge, so there is no mismatch cycle.
- DigitEn has exactly one bit set at all times outside reset.

Optional Feature:
- Macro: SEVENSEG_LEADING_ZERO_BLANK_EN.
- When defined:
  - Zero digits more significant than the highest nonzero digit output SegOut=00000000.
  - The digit is still enabled, so scan timing is unchanged.
  - Digit 0 is never blanked; value 0 shows a single "0".
  - Blanking applies in both modes.
- When undefined: every digit always shows its encoded value, including leading zeros.

Test Plan:
- DIGITS=2, VALUE_W=8, hex: Load with Value=0x45 -> while DigitEn=01, SegOut=01101101; while DigitEn=10, SegOut=01100110; Busy never asserts; Overflow=0.
- DIGITS=4, VALUE_W=16, DecMode=1, Value=1234:
  - Busy high for exactly 17 cycles.
  - Then digit0..3 show 01100110, 01001111, 01011011, 00000110; Overflow=0.
- DIGITS=4, decimal Value=12345 -> after Busy falls, digits show 2345 (01101101, 01100110, 01001111, 01011011) and Overflow=1. Then hex Load of 0x00FF -> Overflow=0.
- REFRESH_DIV=4, DIGITS=4 -> DigitEn holds 0001 for 4 cycles, then 0010, 0100, 1000, then back to 0001 after 16 cycles. Load activity does not disturb the sequence.
- Busy/reset handling:
  - Load Value=9999 decimal, second Load of 1 at cycle 5 -> ignored; result shows 9999.
  - Repeat with Rst asserted at cycle 8 -> Busy=0, SegOut=0 and DigitEn=0 immediately; after release, all digits display 0 (00111111).
- With SEVENSEG_LEADING_ZERO_BLANK_EN, decimal Value=7, DIGITS=4 -> digits 3..1 SegOut=00000000, digit0=00000111. Without the macro, digits 3..1 show 00111111.
